simon_datapath: RTL and testbench

//  Datapath companion to the Simon control FSM. Holds the pattern memory, the

---
 rtl/simon_pkg.sv | 29 ++
 rtl/simon_pattern_mem.sv | 28 ++
 rtl/simon_datapath.sv | 80 ++++++++
 tb/tb_simon_datapath.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants and helpers for the Simon game datapath.
// Level encodings, default widths and the legality test used in hard mode.
package simon_pkg;

    localparam int   PAT_W_DEF   = 4;
    localparam int   ADDR_W_DEF  = 6;
    localparam int   ONE_HOT_W   = 32;
    localparam logic LEVEL_EASY  = 1'b0;
    localparam logic LEVEL_HARD  = 1'b1;

    // Returns 1 iff exactly one bit of p is set. Narrower callers zero-extend.
    function automatic logic one_hot(input logic [ONE_HOT_W-1:0] p);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < ONE_HOT_W; i++) begin
            if (p[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end else begin
                    seen = 1'b1;
                end
            end
        end
        return seen & ~multi;
    endfunction

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern store for the Simon game: synchronous write, asynchronous read.
// Contents are deliberately not reset; the datapath never reads unwritten entries.
module simon_pattern_mem
    import simon_pkg::*;
#(
    parameter int PAT_W  = PAT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PAT_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PAT_W-1:0]  rdata
);

    logic [PAT_W-1:0] mem_r [2**ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon game datapath: level register, saturating count/index, pattern memory
// and the status flags and LED mux consumed by the control FSM.
module simon_datapath
    import simon_pkg::*;
#(
    parameter int PAT_W  = PAT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             level_sw,
    input  logic [PAT_W-1:0] pattern_sw,
    input  logic             set_level,
    input  logic             cnt_count,
    input  logic             clr_count,
    input  logic             cnt_index,
    input  logic             clr_index,
    input  logic             w_en,
    input  logic             read_memory,
    output logic             is_legal,
    output logic             index_lt_count,
    output logic             input_eq_pattern,
    output logic [PAT_W-1:0] pattern_leds
);

    localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] index_r;
    logic              level_r;
    logic [PAT_W-1:0]  rdata_s;
    logic              mem_we_s;

    // Level has no reset: the FSM loads it with set_level while rst is held.
    always_ff @(posedge clk) begin
        if (set_level) begin
            level_r <= level_sw;
        end
    end

    // Saturating counters; clear wins over increment on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {ADDR_W{1'b0}};
            index_r <= {ADDR_W{1'b0}};
        end else begin
            if (clr_count) begin
                count_r <= {ADDR_W{1'b0}};
            end else if (cnt_count && (count_r != CNT_MAX)) begin
                count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (clr_index) begin
                index_r <= {ADDR_W{1'b0}};
            end else if (cnt_index && (index_r != CNT_MAX)) begin
                index_r <= index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Writes use the pre-update count and are suppressed while in reset.
    assign mem_we_s = w_en & ~rst;

    simon_pattern_mem #(
        .PAT_W  (PAT_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (count_r),
        .wdata (pattern_sw),
        .raddr (index_r),
        .rdata (rdata_s)
    );

    assign is_legal         = (level_r == LEVEL_HARD) ? one_hot(ONE_HOT_W'(pattern_sw)) : 1'b1;
    assign index_lt_count   = (index_r < count_r);
    assign input_eq_pattern = (pattern_sw == rdata_s);
    assign pattern_leds     = read_memory ? rdata_s : pattern_sw;

endmodule

// File: tb/tb_simon_datapath.sv
// Self-checking bench for simon_datapath: directed scenarios plus randomized
// strobes, all compared against an array-based reference model.
module tb_simon_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       level_sw;
    logic [3:0] pattern_sw;
    logic       set_level, cnt_count, clr_count, cnt_index, clr_index, w_en, read_memory;
    logic       is_legal, index_lt_count, input_eq_pattern;
    logic [3:0] pattern_leds;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_mem [64];
    bit         m_wr  [64];
    int         m_count;
    int         m_index;
    logic       m_level;
    logic [3:0] last_fill;

    simon_datapath dut (
        .clk              (clk),
        .rst              (rst),
        .level_sw         (level_sw),
        .pattern_sw       (pattern_sw),
        .set_level        (set_level),
        .cnt_count        (cnt_count),
        .clr_count        (clr_count),
        .cnt_index        (cnt_index),
        .clr_index        (clr_index),
        .w_en             (w_en),
        .read_memory      (read_memory),
        .is_legal         (is_legal),
        .index_lt_count   (index_lt_count),
        .input_eq_pattern (input_eq_pattern),
        .pattern_leds     (pattern_leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model in its current state.
    task automatic check_all(input string tag);
        logic exp_legal;
        exp_legal = m_level ? ($countones(pattern_sw) == 1) : 1'b1;
        chk({tag, ".is_legal"}, {3'b000, is_legal}, {3'b000, exp_legal});
        chk({tag, ".lt"}, {3'b000, index_lt_count}, {3'b000, (m_index < m_count)});
        if (m_wr[m_index]) begin
            chk({tag, ".eq"}, {3'b000, input_eq_pattern},
                {3'b000, (pattern_sw == m_mem[m_index])});
            chk({tag, ".leds"}, pattern_leds, read_memory ? m_mem[m_index] : pattern_sw);
        end else if (!read_memory) begin
            chk({tag, ".leds"}, pattern_leds, pattern_sw);
        end
    endtask

    // One clock edge: model applies the strobes held across the edge, strobes then drop.
    task automatic step();
        logic s_set, s_lvl, s_cc, s_clc, s_ci, s_cli, s_we;
        logic [3:0] s_pat;
        s_set = set_level; s_lvl = level_sw; s_cc = cnt_count; s_clc = clr_count;
        s_ci = cnt_index; s_cli = clr_index; s_we = w_en; s_pat = pattern_sw;
        @(posedge clk);
        if (s_set) m_level = s_lvl;
        if (rst) begin
            m_count = 0;
            m_index = 0;
        end else begin
            if (s_we) begin
                m_mem[m_count] = s_pat;
                m_wr[m_count]  = 1'b1;
            end
            if (s_clc) m_count = 0;
            else if (s_cc) m_count = (m_count >= 63) ? 63 : m_count + 1;
            if (s_cli) m_index = 0;
            else if (s_ci) m_index = (m_index >= 63) ? 63 : m_index + 1;
        end
        #1;
        set_level = 1'b0; cnt_count = 1'b0; clr_count = 1'b0;
        cnt_index = 1'b0; clr_index = 1'b0; w_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_wr[i] = 1'b0;
        m_count = 0; m_index = 0; m_level = 1'b0;
        rst = 1'b1; level_sw = 1'b1; pattern_sw = 4'b0000;
        set_level = 1'b1; cnt_count = 1'b0; clr_count = 1'b0;
        cnt_index = 1'b0; clr_index = 1'b0; w_en = 1'b0; read_memory = 1'b0;

        // Level captured during reset, hard mode legality
        step();
        rst = 1'b0;
        #1;
        chk("reset.lt", {3'b000, index_lt_count}, 4'h0);
        pattern_sw = 4'b0110; #1;
        chk("hard_0110", {3'b000, is_legal}, 4'h0);
        check_all("hard_0110");
        pattern_sw = 4'b0100; #1;
        chk("hard_0100", {3'b000, is_legal}, 4'h1);
        level_sw = 1'b0; set_level = 1'b1; step();
        pattern_sw = 4'b1111; #1;
        chk("easy_1111", {3'b000, is_legal}, 4'h1);
        check_all("easy_1111");

        // Write and playback
        pattern_sw = 4'b1010; w_en = 1'b1; step();
        read_memory = 1'b1; pattern_sw = 4'b0000; #1;
        chk("play.leds", pattern_leds, 4'b1010);
        chk("play.lt0", {3'b000, index_lt_count}, 4'h0);
        cnt_count = 1'b1; step();
        chk("play.lt1", {3'b000, index_lt_count}, 4'h1);
        check_all("play");

        // Repeat compare over {0001,0010}
        clr_count = 1'b1; step();
        pattern_sw = 4'b0001; w_en = 1'b1; cnt_count = 1'b1; step();
        pattern_sw = 4'b0010; w_en = 1'b1; step();
        clr_index = 1'b1; step();
        pattern_sw = 4'b0001; #1;
        chk("rep.eq0001", {3'b000, input_eq_pattern}, 4'h1);
        pattern_sw = 4'b0011; #1;
        chk("rep.eq0011", {3'b000, input_eq_pattern}, 4'h0);
        cnt_index = 1'b1; step();
        pattern_sw = 4'b0010; #1;
        chk("rep.eq0010", {3'b000, input_eq_pattern}, 4'h1);
        chk("rep.lt", {3'b000, index_lt_count}, 4'h0);
        check_all("rep");

        // Clear beats increment on the same edge
        clr_index = 1'b1; clr_count = 1'b1; cnt_count = 1'b1; step();
        chk("prio.lt", {3'b000, index_lt_count}, 4'h0);
        check_all("prio");

        // Fill all 64 entries; the last write lands on the saturated address 63
        for (int i = 0; i < 64; i++) begin
            pattern_sw = 4'($urandom_range(0, 15));
            last_fill  = pattern_sw;
            w_en = 1'b1; cnt_count = 1'b1; step();
        end
        for (int i = 0; i < 70; i++) begin
            cnt_index = 1'b1; step();
            check_all("sat_sweep");
        end
        chk("sat.leds63", pattern_leds, last_fill);
        chk("sat.lt", {3'b000, index_lt_count}, 4'h0);

        // Randomized strobes with occasional reset
        for (int i = 0; i < 300; i++) begin
            rst         = ($urandom_range(0, 39) == 0);
            level_sw    = 1'($urandom_range(0, 1));
            set_level   = ($urandom_range(0, 7) == 0);
            pattern_sw  = 4'($urandom_range(0, 15));
            cnt_count   = 1'($urandom_range(0, 1));
            clr_count   = ($urandom_range(0, 15) == 0);
            cnt_index   = 1'($urandom_range(0, 1));
            clr_index   = ($urandom_range(0, 7) == 0);
            w_en        = 1'($urandom_range(0, 1));
            read_memory = 1'($urandom_range(0, 1));
            step();
            rst = 1'b0;
            #1;
            check_all("rand");
        end

        // Asynchronous reset between edges
        level_sw = 1'b1; set_level = 1'b1; clr_count = 1'b1; clr_index = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            pattern_sw = 4'(i + 3); w_en = 1'b1; cnt_count = 1'b1; step();
        end
        for (int i = 0; i < 3; i++) begin
            cnt_index = 1'b1; step();
        end
        read_memory = 1'b1; #1;
        chk("pre_rst.lt", {3'b000, index_lt_count}, 4'h1);
        check_all("pre_rst");
        #1;
        rst = 1'b1;
        m_count = 0; m_index = 0;
        #1;
        chk("async.lt", {3'b000, index_lt_count}, 4'h0);
        chk("async.leds", pattern_leds, 4'd3);
        pattern_sw = 4'b0110; #1;
        chk("async.level", {3'b000, is_legal}, 4'h0);
        check_all("async");
        step();
        rst = 1'b0;
        #1;
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
